// File: rtl/ordering_packer.sv
// ordering_packer
// Host-side loader for one city ordering. The host writes one city index per
// position into a lane buffer. The buffer holds 8 lanes per packed word. On
// start, the packed words are streamed as a gap-free burst of CITY_DIV beats
// in exchange write-port format, where word k holds positions 8k..8k+7.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   wr_valid  host write strobe (accepted in IDLE only)
//   wr_addr   position index 0..CITY_NUM-1 (larger values are ignored)
//   wr_data   city index stored at wr_addr
//   wr_ready  high in IDLE (writes accepted)
//   clear     clears the written-position mask (IDLE only; data is kept)
//   start     requests a burst (IDLE only, not queued)
//   busy      high while the burst is being sent
//   complete  every position has been written since the last clear or reset
//   out_valid beat qualifier
//   out_data  packed word; lane j is at [j*CITY_LOG +: CITY_LOG]
//   done      one-cycle pulse after the last beat
module ordering_packer #(
  parameter int CITY_NUM = 30,
  parameter int CITY_LOG = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_valid,
  input  logic [CITY_LOG-1:0]   wr_addr,
  input  logic [CITY_LOG-1:0]   wr_data,
  output logic                  wr_ready,
  input  logic                  clear,
  input  logic                  start,
  output logic                  busy,
  output logic                  complete,
  output logic                  out_valid,
  output logic [8*CITY_LOG-1:0] out_data,
  output logic                  done
);

  localparam int CITY_DIV = (CITY_NUM + 7) / 8;
  localparam int WW       = (CITY_DIV > 1) ? $clog2(CITY_DIV) : 1;
  localparam int DEPTH    = 1 << CITY_LOG;

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t                r_state, w_state_nxt;
  logic [WW-1:0]         r_word, w_word_nxt;
  logic [CITY_LOG-1:0]   r_lane [DEPTH];
  logic [CITY_NUM-1:0]   r_mask, w_mask_nxt;
  logic                  r_complete;
  logic                  r_done;
  logic [8*CITY_LOG-1:0] r_data, w_beat;
  logic                  w_wr_en, w_load, w_last;
  int unsigned           w_pos;

  // Next-state logic and beat sequencing.
  always_comb begin
    w_wr_en     = (r_state == S_IDLE) && wr_valid &&
                  ({1'b0, wr_addr} < (CITY_LOG+1)'(CITY_NUM));
    w_last      = (r_word == WW'(CITY_DIV - 1));
    w_state_nxt = r_state;
    w_word_nxt  = r_word;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_SEND;
          w_word_nxt  = '0;
          w_load      = 1'b1;
        end
      end
      S_SEND: begin
        if (w_last) begin
          w_state_nxt = S_IDLE;
          w_word_nxt  = '0;
        end else begin
          w_word_nxt = r_word + WW'(1);
          w_load     = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // In the same cycle, clear takes priority over a write for the mask.
  always_comb begin
    w_mask_nxt = r_mask;
    if (w_wr_en) w_mask_nxt[wr_addr] = 1'b1;
    if ((r_state == S_IDLE) && clear) w_mask_nxt = '0;
  end

  // Beat assembly for word w_word_nxt. The data register is loaded one cycle
  // ahead of the beat. A write in the same cycle as start is forwarded, so
  // beat 0 carries that write. Padding lanes always transmit 0.
  always_comb begin
    w_beat = '0;
    w_pos  = 0;
    for (int unsigned j = 0; j < 8; j++) begin
      w_pos = 32'(w_word_nxt) * 8 + j;
      if (w_pos < CITY_NUM) begin
        if (w_wr_en && (CITY_LOG'(w_pos) == wr_addr))
          w_beat[j*CITY_LOG +: CITY_LOG] = wr_data;
        else
          w_beat[j*CITY_LOG +: CITY_LOG] = r_lane[CITY_LOG'(w_pos)];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_word     <= '0;
      r_mask     <= '0;
      r_complete <= 1'b0;
      r_done     <= 1'b0;
      r_data     <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) r_lane[i] <= '0;
    end else begin
      r_word     <= w_word_nxt;
      r_mask     <= w_mask_nxt;
      r_complete <= &w_mask_nxt;
      r_done     <= (r_state == S_SEND) && w_last;
      if (w_load)  r_data <= w_beat;
      if (w_wr_en) r_lane[wr_addr] <= wr_data;
    end
  end

  assign wr_ready  = (r_state == S_IDLE);
  assign busy      = (r_state == S_SEND);
  assign out_valid = (r_state == S_SEND);
  assign out_data  = r_data;
  assign complete  = r_complete;
  assign done      = r_done;

endmodule

// File: tb/tb_ordering_packer.sv
// Directed bench for ordering_packer (CITY_NUM=30, CITY_LOG=5, 4 beats).
module tb_ordering_packer;

  localparam int N = 30;
  localparam int L = 5;
  localparam int D = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           wr_valid, clear, start;
  logic [L-1:0]   wr_addr, wr_data;
  logic           wr_ready, busy, complete, out_valid, done;
  logic [8*L-1:0] out_data;

  logic [L-1:0]   mdl [N];
  logic [8*L-1:0] cap [D];
  int             n_chk = 0;
  int             n_err = 0;

  ordering_packer #(.CITY_NUM(N), .CITY_LOG(L)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ready(wr_ready), .clear(clear), .start(start),
    .busy(busy), .complete(complete), .out_valid(out_valid),
    .out_data(out_data), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8*L-1:0] pack(input int k);
    logic [8*L-1:0] r;
    r = '0;
    for (int j = 0; j < 8; j++)
      if (k*8 + j < N) r[j*L +: L] = mdl[k*8 + j];
    return r;
  endfunction

  task automatic wr(input int a, input int d);
    wr_valid = 1'b1;
    wr_addr  = L'(a);
    wr_data  = L'(d);
    if (a < N) mdl[a] = L'(d);
    tick();
    wr_valid = 1'b0;
  endtask

  // The caller raises start (and an optional same-cycle write) before calling.
  // With hz set, start/write/clear are driven during every beat.
  task automatic burst(input bit hz);
    tick();
    start = 1'b0; wr_valid = 1'b0; clear = 1'b0;
    for (int k = 0; k < D; k++) begin
      chk($sformatf("valid%0d", k), 64'(out_valid), 64'd1);
      chk($sformatf("busy%0d", k), 64'(busy), 64'd1);
      chk($sformatf("wrrdy%0d", k), 64'(wr_ready), 64'd0);
      chk($sformatf("beat%0d", k), 64'(out_data), 64'(pack(k)));
      chk($sformatf("nodone%0d", k), 64'(done), 64'd0);
      cap[k] = out_data;
      if (hz) begin
        start = 1'b1; wr_valid = 1'b1; wr_addr = 5'd1; wr_data = 5'd31; clear = 1'b1;
      end
      tick();
      start = 1'b0; wr_valid = 1'b0; clear = 1'b0;
    end
    chk("done", 64'(done), 64'd1);
    chk("busy_end", 64'(busy), 64'd0);
    chk("valid_end", 64'(out_valid), 64'd0);
    chk("hold", 64'(out_data), 64'(cap[D-1]));
    tick();
    chk("done_pulse", 64'(done), 64'd0);
    chk("no_requeue", 64'(out_valid), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; wr_valid = 1'b0; clear = 1'b0; start = 1'b0;
    wr_addr = '0; wr_data = '0;
    for (int i = 0; i < N; i++) mdl[i] = '0;

    // Reset values (asynchronous, before any clock edge)
    #3;
    chk("rst_wrrdy", 64'(wr_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_cmpl", 64'(complete), 64'd0);
    tick(); tick();
    reset = 1'b1;
    tick();
    chk("post_rst_valid", 64'(out_valid), 64'd0);

    // Burst with no writes: four zero beats
    start = 1'b1;
    burst(1'b0);

    // Load positions 0..28; out-of-range addresses are ignored
    for (int p = 0; p < N-1; p++) wr(p, N-1-p);
    wr(30, 9);
    wr(31, 9);
    chk("cmpl_29of30", 64'(complete), 64'd0);
    wr(29, 0);
    chk("cmpl_all", 64'(complete), 64'd1);
    start = 1'b1;
    burst(1'b0);
    chk("b0_lane0", 64'(cap[0][4:0]), 64'd29);
    chk("b0_lane7", 64'(cap[0][39:35]), 64'd22);
    chk("b3_const", 64'(cap[3]), 64'h110C85);

    // start/write/clear during SEND are ignored
    start = 1'b1;
    burst(1'b1);
    chk("cmpl_kept", 64'(complete), 64'd1);
    start = 1'b1;
    burst(1'b0);
    chk("pos1_kept", 64'(cap[0][9:5]), 64'd28);

    // clear drops complete but keeps data
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_cmpl", 64'(complete), 64'd0);
    start = 1'b1;
    burst(1'b0);

    // Write and start in the same cycle: the write must appear in beat 0
    wr_valid = 1'b1; wr_addr = 5'd0; wr_data = 5'd7; mdl[0] = 5'd7;
    start = 1'b1;
    burst(1'b0);
    chk("bypass_lane0", 64'(cap[0][4:0]), 64'd7);

    // Async reset during beat 2: burst aborts with no done
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("beat2_valid", 64'(out_valid), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("abort_valid", 64'(out_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_data", 64'(out_data), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    #1 reset = 1'b1;
    for (int i = 0; i < N; i++) mdl[i] = '0;
    tick();
    chk("abort_done_a", 64'(done), 64'd0);
    chk("abort_valid_a", 64'(out_valid), 64'd0);
    tick();
    chk("abort_done_b", 64'(done), 64'd0);
    chk("abort_cmpl", 64'(complete), 64'd0);
    start = 1'b1;
    burst(1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ordering_packer.md
Name: ordering_packer

Overview:
- Write-side counterpart of the replica exchange buffer's ordering read-out.
- Host loads one city index per write into a per-position ordering buffer, packed 8 lanes per word.
- On start, streams the packed words as a valid-qualified burst of CITY_DIV consecutive beats in the same format the exchange write port consumes (word k holds positions 8k..8k+7).
- Used to seed a replica's initial route and to inject host-modified routes.

Parameters:
CITY_NUM, 30, number of cities (positions in one ordering)
CITY_LOG, 5, bits per city index; must satisfy 2**CITY_LOG >= CITY_NUM
CITY_DIV, (CITY_NUM+7)/8, packed words per ordering (derived, not overridden)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset (reset==0 resets)
wr_valid  in  1  host write strobe
wr_addr  in  CITY_LOG  position index 0..CITY_NUM-1
wr_data  in  CITY_LOG  city index stored at wr_addr
wr_ready  out  1  writes accepted (IDLE only)
clear  in  1  clears written-position mask
start  in  1  request burst transmit
busy  out  1  high while in SEND
complete  out  1  every position 0..CITY_NUM-1 written since last clear/reset
out_valid  out  1  beat valid to exchange write port
out_data  out  8*CITY_LOG  packed word, lane j at bits [j*CITY_LOG +: CITY_LOG]
done  out  1  one-cycle pulse after last beat

Behaviour:
- Reset (async, reset==0): state IDLE; buffer lanes all 0; mask all 0; out_valid=0, out_data=0, done=0, busy=0, wr_ready=1, complete=0. Reset mid-SEND aborts the burst immediately; no further beats, no done.
- States: IDLE, SEND. IDLE->SEND on start; SEND->IDLE after beat CITY_DIV-1 is issued.
- Write (IDLE, wr_valid, wr_addr<CITY_NUM): lane wr_addr[2:0] of word wr_addr[CITY_LOG-1:3] <= wr_data; mask[wr_addr] <= 1. wr_addr>=CITY_NUM: write ignored, no state change. Rewriting a position overwrites it; mask stays 1.
- Writes in SEND are ignored (wr_ready=0); the host must not assume buffering.
- clear in IDLE: mask <= 0; buffer data kept. clear in SEND ignored. clear and write together in IDLE: clear wins for mask, data is still written.
- complete is a registered AND of mask[0..CITY_NUM-1], valid the cycle after the last contributing write.
- start in IDLE at cycle t: busy=1 from t+1. Beat k (k=0..CITY_DIV-1) has out_valid=1 at cycle t+1+k, with no gaps and no backpressure. done=1 at cycle t+1+CITY_DIV for one cycle; busy=0 in the same cycle.
- start in SEND is ignored, not queued. start with complete=0 is still honoured; unwritten lanes transmit their current value (0 after reset).
- Write and start in the same IDLE cycle: the write is committed and must appear in the burst (bypass into the beat read).
- Padding lanes in the last word (positions >= CITY_NUM) always transmit 0.
- out_data holds its last beat value when out_valid=0; the consumer qualifies on out_valid only.
- Word counter wraps CITY_DIV-1 -> 0 at end of SEND.

Test Plan:
- Reset check: reset=0 then 1 -> all outputs at reset values; start with no writes -> 4 beats of 0, done at t+5.
- Load: write positions 0..29 with city=29-pos, then start -> beat0 lanes 29..22, beat3 lanes 5,4,3,2,1,0,0,0 (padding lanes 0); complete=1 before start.
- Boundaries: wr_addr=30 and 31 ignored, complete stays 0 with only 29 positions written. Position 29 written last -> complete=1 the next cycle. clear -> complete=0, data retained in the next burst.
- Same-cycle write and start: write pos 0 = 7 in the same cycle as start -> beat0 lane0=7.
- SEND hazards: start and writes during SEND ignored -> exactly 4 beats, buffer unchanged in the following burst.
- Async reset at beat 2: out_valid falls without a clock edge, no done; a new start sends 4 zero beats.
